// File: rtl/gpio_cmd_decoder.sv
// GPIO command decoder: turns strobed processor command words into datapath controls and a response word.
// Optional build macro: GPIO_DEC_BER_SNAPSHOT_EN (coherent per-channel BER sample/error capture).
module gpio_cmd_decoder #(
  parameter int unsigned NB_GPIOS        = 32,
  parameter int unsigned BRAM_ADDR_WIDTH = 15,
  parameter int unsigned NB_BER_CNT      = 64,
  parameter int unsigned MEM_RD_LAT      = 2,
  parameter int unsigned RST_PULSE_LEN   = 4
) (
  input  logic                       clk100,
  input  logic                       i_resetn,
  input  logic [NB_GPIOS-1:0]        gpo0,
  output logic [NB_GPIOS-1:0]        gpi0,
  input  logic [NB_BER_CNT-1:0]      i_ber_samp_i,
  input  logic [NB_BER_CNT-1:0]      i_ber_samp_q,
  input  logic [NB_BER_CNT-1:0]      i_ber_err_i,
  input  logic [NB_BER_CNT-1:0]      i_ber_err_q,
  input  logic                       i_mem_full,
  input  logic [NB_GPIOS-1:0]        i_data_log_from_mem,
  output logic                       o_rst,
  output logic                       o_enb_tx,
  output logic                       o_enb_rx,
  output logic [1:0]                 o_phase_sel,
  output logic                       o_run_log,
  output logic                       o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem
);

  localparam int unsigned BER_W  = 64;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned LAT_W  = $clog2(MEM_RD_LAT + 1);
  localparam int unsigned RST_W  = $clog2(RST_PULSE_LEN + 1);

  localparam logic [7:0] OP_RESET    = 8'd0;
  localparam logic [7:0] OP_EN_TX    = 8'd1;
  localparam logic [7:0] OP_EN_RX    = 8'd2;
  localparam logic [7:0] OP_PH_SEL   = 8'd3;
  localparam logic [7:0] OP_RUN_MEM  = 8'd4;
  localparam logic [7:0] OP_READ_MEM = 8'd5;
  localparam logic [7:0] OP_ADDR_MEM = 8'd6;
  localparam logic [7:0] OP_BER_S_I  = 8'd7;
  localparam logic [7:0] OP_BER_S_Q  = 8'd8;
  localparam logic [7:0] OP_BER_E_I  = 8'd9;
  localparam logic [7:0] OP_BER_E_Q  = 8'd10;
  localparam logic [7:0] OP_BER_H    = 8'd11;
  localparam logic [7:0] OP_MEM_FULL = 8'd12;

  typedef enum logic {ST_IDLE, ST_MEM_WAIT} state_e;

  state_e                     state_q, state_d;
  logic [NB_GPIOS-1:0]        gpo_q, gpo_d;
  logic                       strb_prev_q, strb_prev_d;
  logic [LAT_W-1:0]           lat_cnt_q, lat_cnt_d;
  logic [RST_W-1:0]           rst_cnt_q, rst_cnt_d;
  logic                       rst_q, rst_d;
  logic                       enb_tx_q, enb_tx_d;
  logic                       enb_rx_q, enb_rx_d;
  logic [1:0]                 phase_q, phase_d;
  logic                       run_q, run_d;
  logic                       read_q, read_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NB_GPIOS-1:0]        gpi_q, gpi_d;
  logic [HALF_W-1:0]          hi_q, hi_d;

  logic [7:0]                 opcode;
  logic [22:0]                arg;
  logic                       fire;
  logic [BER_W-1:0]           ber_sel;
  logic                       unused_arg_bits;

  assign opcode          = gpo_q[31:24];
  assign arg             = gpo_q[22:0];
  assign fire            = gpo_q[23] & ~strb_prev_q;
  assign unused_arg_bits = ^arg[22:BRAM_ADDR_WIDTH];

`ifdef GPIO_DEC_BER_SNAPSHOT_EN
  logic [NB_BER_CNT-1:0] shd_err_i_q, shd_err_i_d;
  logic [NB_BER_CNT-1:0] shd_err_q_q, shd_err_q_d;
`endif

  // Command decode, reset pulse counter and memory-read wait sequencing.
  always_comb begin
    gpo_d       = gpo0;
    strb_prev_d = gpo_q[23];
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    rst_cnt_d   = (rst_cnt_q != '0) ? rst_cnt_q - RST_W'(1) : rst_cnt_q;
    enb_tx_d    = enb_tx_q;
    enb_rx_d    = enb_rx_q;
    phase_d     = phase_q;
    run_d       = 1'b0;
    read_d      = read_q;
    addr_d      = addr_q;
    gpi_d       = gpi_q;
    hi_d        = hi_q;
    ber_sel     = '0;
`ifdef GPIO_DEC_BER_SNAPSHOT_EN
    shd_err_i_d = shd_err_i_q;
    shd_err_q_d = shd_err_q_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          case (opcode)
            OP_RESET: begin
              rst_cnt_d = RST_W'(RST_PULSE_LEN);
              enb_tx_d  = 1'b0;
              enb_rx_d  = 1'b0;
              phase_d   = 2'b00;
              read_d    = 1'b0;
              gpi_d     = '0;
            end
            OP_EN_TX:  enb_tx_d = arg[0];
            OP_EN_RX:  enb_rx_d = arg[0];
            OP_PH_SEL: phase_d  = arg[1:0];
            OP_RUN_MEM: begin
              run_d  = 1'b1;
              read_d = 1'b0;
            end
            OP_READ_MEM: begin
              read_d    = 1'b1;
              addr_d    = arg[BRAM_ADDR_WIDTH-1:0];
              lat_cnt_d = LAT_W'(MEM_RD_LAT);
              state_d   = ST_MEM_WAIT;
            end
            OP_ADDR_MEM: begin
              if (read_q) begin
                addr_d    = arg[BRAM_ADDR_WIDTH-1:0];
                lat_cnt_d = LAT_W'(MEM_RD_LAT);
                state_d   = ST_MEM_WAIT;
              end else begin
                gpi_d = '1;
              end
            end
            OP_BER_S_I, OP_BER_S_Q, OP_BER_E_I, OP_BER_E_Q: begin
              case (opcode)
                OP_BER_S_I: ber_sel = BER_W'(i_ber_samp_i);
                OP_BER_S_Q: ber_sel = BER_W'(i_ber_samp_q);
`ifdef GPIO_DEC_BER_SNAPSHOT_EN
                OP_BER_E_I: ber_sel = BER_W'(shd_err_i_q);
                default:    ber_sel = BER_W'(shd_err_q_q);
`else
                OP_BER_E_I: ber_sel = BER_W'(i_ber_err_i);
                default:    ber_sel = BER_W'(i_ber_err_q);
`endif
              endcase
`ifdef GPIO_DEC_BER_SNAPSHOT_EN
              if (opcode == OP_BER_S_I) shd_err_i_d = i_ber_err_i;
              if (opcode == OP_BER_S_Q) shd_err_q_d = i_ber_err_q;
`endif
              gpi_d = NB_GPIOS'(ber_sel[HALF_W-1:0]);
              hi_d  = ber_sel[BER_W-1:HALF_W];
            end
            OP_BER_H:    gpi_d = NB_GPIOS'(hi_q);
            OP_MEM_FULL: gpi_d = NB_GPIOS'(i_mem_full);
            default:     gpi_d = '1;
          endcase
        end
      end
      ST_MEM_WAIT: begin
        // Strobe edges seen here are intentionally ignored.
        if (lat_cnt_q <= LAT_W'(1)) begin
          gpi_d   = i_data_log_from_mem;
          state_d = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rst_d = (rst_cnt_d != '0);
  end

  always_ff @(posedge clk100) begin
    if (!i_resetn) begin
      state_q     <= ST_IDLE;
      gpo_q       <= '0;
      strb_prev_q <= 1'b0;
      lat_cnt_q   <= '0;
      rst_cnt_q   <= '0;
      rst_q       <= 1'b0;
      enb_tx_q    <= 1'b0;
      enb_rx_q    <= 1'b0;
      phase_q     <= 2'b00;
      run_q       <= 1'b0;
      read_q      <= 1'b0;
      addr_q      <= '0;
      gpi_q       <= '0;
      hi_q        <= '0;
    end else begin
      state_q     <= state_d;
      gpo_q       <= gpo_d;
      strb_prev_q <= strb_prev_d;
      lat_cnt_q   <= lat_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      rst_q       <= rst_d;
      enb_tx_q    <= enb_tx_d;
      enb_rx_q    <= enb_rx_d;
      phase_q     <= phase_d;
      run_q       <= run_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
      gpi_q       <= gpi_d;
      hi_q        <= hi_d;
    end
  end

`ifdef GPIO_DEC_BER_SNAPSHOT_EN
  always_ff @(posedge clk100) begin
    if (!i_resetn) begin
      shd_err_i_q <= '0;
      shd_err_q_q <= '0;
    end else begin
      shd_err_i_q <= shd_err_i_d;
      shd_err_q_q <= shd_err_q_d;
    end
  end
`endif

  assign gpi0              = gpi_q;
  assign o_rst             = rst_q;
  assign o_enb_tx          = enb_tx_q;
  assign o_enb_rx          = enb_rx_q;
  assign o_phase_sel       = phase_q;
  assign o_run_log         = run_q;
  assign o_read_log        = read_q;
  assign o_addr_log_to_mem = addr_q;

endmodule
